// File: rtl/ram_arb_pkg.sv
// Shared definitions for the round-robin RAM arbiter: FSM encoding and default widths.
package ram_arb_pkg;

  // Default geometry. The RAM has 2**DEF_ADDR_W words of DEF_DATA_W bits.
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;

  // Every command walks IDLE -> ACCESS -> RESP -> IDLE and never skips a state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. The search starts at the requester after the
// last one served (ptr) and wraps, so ptr itself gets the lowest priority.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // The search runs from the far end back towards ptr+1, so the candidate
  // nearest to ptr+1 is written last and wins.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    grant  = '0;
    idx    = '0;
    any    = |req;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter that shares one single-port RAM among NUM_REQ requesters.
// Each accepted command takes three cycles: accept (IDLE), RAM strobe (ACCESS)
// and response (RESP).
module ram_arbiter_rr
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          busy,
  output logic                          ram_cs,
  output logic                          ram_read,
  output logic                          ram_write,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [DATA_W-1:0]             ram_data_in,
  input  logic [DATA_W-1:0]             ram_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic               w_hs;

  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_we;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_id;
  logic               r_we;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ram_cs;
  logic               r_ram_read;
  logic               r_ram_write;
  logic [ADDR_W-1:0]  r_ram_address;
  logic [DATA_W-1:0]  r_ram_data_in;

  // Unpack the flattened command buses into per-requester slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_win_idx),
    .any   (w_any)
  );

  assign w_sel_addr  = w_addr[w_win_idx];
  assign w_sel_wdata = w_wdata[w_win_idx];
  assign w_sel_we    = req_we[w_win_idx];

  // Offers go out only in IDLE; a request that stays valid through ACCESS/RESP
  // simply competes again in the next IDLE cycle.
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign w_hs      = (r_state == ST_IDLE) && w_any;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: the fixed three-step sequence, leaving IDLE only on a handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs) w_state_next = ST_ACCESS;
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Command latch, priority pointer and RAM-side registers. The strobes are
  // loaded on the handshake edge, so they are high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= IDX_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_we          <= 1'b0;
      r_ram_cs      <= 1'b0;
      r_ram_read    <= 1'b0;
      r_ram_write   <= 1'b0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_ram_cs    <= w_hs;
      r_ram_read  <= w_hs & ~w_sel_we;
      r_ram_write <= w_hs & w_sel_we;
      if (w_hs) begin
        r_ptr         <= w_win_idx;
        r_id          <= w_win_idx;
        r_we          <= w_sel_we;
        r_ram_address <= w_sel_addr;
        r_ram_data_in <= w_sel_wdata;
      end
    end
  end

  // Keep the last read result so rsp_rdata holds steady after a read and across writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (r_state == ST_RESP && !r_we) begin
      r_rdata <= ram_data_out;
    end
  end

  // The RAM registers its output on the edge that ends ACCESS, so during RESP
  // the fresh word is presented directly; afterwards the captured copy is shown.
  assign rsp_rdata   = (r_state == ST_RESP && !r_we) ? ram_data_out : r_rdata;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_id      = r_id;
  assign busy        = (r_state != ST_IDLE);
  assign ram_cs      = r_ram_cs;
  assign ram_read    = r_ram_read;
  assign ram_write   = r_ram_write;
  assign ram_address = r_ram_address;
  assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench for ram_arbiter_rr with three requesters and a small RAM model
// (registered read, contents cleared by reset).
module tb_ram_arbiter_rr;

  localparam int NR = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  v;
  logic [NR-1:0]  we;
  logic [AW-1:0]  a [NR];
  logic [DW-1:0]  d [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;

  logic [NR-1:0]  req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [DW-1:0]  rsp_rdata;
  logic           busy;
  logic           ram_cs, ram_read, ram_write;
  logic [AW-1:0]  ram_address;
  logic [DW-1:0]  ram_data_in;
  logic [DW-1:0]  ram_data_out;

  logic [DW-1:0]  mem [16];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = d[i];
    end
  end

  ram_arbiter_rr #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (v),
    .req_we       (we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .ram_cs       (ram_cs),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // RAM model: write on cs&write, registered read on cs&read, cleared on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      ram_data_out <= '0;
    end else if (ram_cs) begin
      if (ram_write) mem[ram_address] <= ram_data_in;
      if (ram_read)  ram_data_out <= mem[ram_address];
    end
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (!rst && rsp_valid)
      $display("txn done: id=%0d rdata=0x%02h t=%0t", rsp_id, rsp_rdata, $time);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One full command: offer vv in IDLE, expect requester id to win, check the
  // RAM strobe cycle and the response cycle. Inputs stay held throughout.
  task automatic txn(input logic [NR-1:0] vv, input int id, input bit exp_we,
                     input bit chk_rd, input int exp_rd);
    @(negedge clk); v = vv; #1;
    chk("ready", int'(req_ready), 1 << id);
    chk("idle_busy", int'(busy), 0);
    @(negedge clk); #1;
    chk("acc_ready", int'(req_ready), 0);
    chk("acc_cs", int'(ram_cs), 1);
    chk("acc_wr", int'(ram_write), int'(exp_we));
    chk("acc_rd", int'(ram_read), int'(!exp_we));
    chk("acc_addr", int'(ram_address), int'(a[id]));
    if (exp_we) chk("acc_din", int'(ram_data_in), int'(d[id]));
    chk("acc_rspv", int'(rsp_valid), 0);
    @(negedge clk); #1;
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("rsp_id", int'(rsp_id), id);
    chk("rsp_cs", int'(ram_cs), 0);
    if (chk_rd) chk("rsp_rdata", int'(rsp_rdata), exp_rd);
  endtask

  initial begin
    rst = 1'b1; v = '0; we = '0;
    for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rspv", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_rdata", int'(rsp_rdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_strobes", int'({ram_cs, ram_read, ram_write}), 0);
    chk("rst_addr", int'(ram_address), 0);
    chk("rst_din", int'(ram_data_in), 0);
    rst = 1'b0;

    // 2: req0 writes 0xA5 at 3, req1 reads it back
    we[0] = 1'b1; a[0] = 4'd3; d[0] = 8'hA5;
    txn(3'b001, 0, 1'b1, 1'b0, 0);
    we[1] = 1'b0; a[1] = 4'd3;
    txn(3'b010, 1, 1'b0, 1'b1, 8'hA5);
    @(negedge clk); v = '0; #1;
    chk("hold_rspv", int'(rsp_valid), 0);
    chk("hold_rdata", int'(rsp_rdata), 8'hA5);

    // 3: two requesters both valid -> alternate 0,1,0,1 (ptr is 1 now)
    we = '0; a[0] = 4'd1; a[1] = 4'd2;
    txn(3'b011, 0, 1'b0, 1'b1, 0);
    txn(3'b011, 1, 1'b0, 1'b1, 0);
    txn(3'b011, 0, 1'b0, 1'b1, 0);
    txn(3'b011, 1, 1'b0, 1'b1, 0);

    // 4: three requesters, wrap from 2 to 0, then lone req2 served twice
    a[2] = 4'd3;
    txn(3'b111, 2, 1'b0, 1'b1, 8'hA5);
    txn(3'b111, 0, 1'b0, 1'b1, 0);
    txn(3'b111, 1, 1'b0, 1'b1, 0);
    txn(3'b100, 2, 1'b0, 1'b1, 8'hA5);
    txn(3'b100, 2, 1'b0, 1'b1, 8'hA5);
    // idle cycles must not rotate priority: ptr=2 -> req0 next, then req1
    @(negedge clk); v = '0;
    repeat (3) @(negedge clk);
    txn(3'b011, 0, 1'b0, 1'b1, 0);
    txn(3'b011, 1, 1'b0, 1'b1, 0);

    // 5: top address, then address 0 still holding its reset value
    we[0] = 1'b1; a[0] = 4'd15; d[0] = 8'hFF;
    txn(3'b001, 0, 1'b1, 1'b0, 0);
    chk("wr_keeps_rdata", int'(rsp_rdata), 0);
    we[1] = 1'b0; a[1] = 4'd15;
    txn(3'b010, 1, 1'b0, 1'b1, 8'hFF);
    we[0] = 1'b0; a[0] = 4'd0;
    txn(3'b001, 0, 1'b0, 1'b1, 8'h00);

    // 6: reset during the ACCESS cycle of a read (ptr is 0 before reset)
    a[0] = 4'd15;
    @(negedge clk); v = 3'b001; #1;
    chk("pre_rst_ready", int'(req_ready), 1);
    @(negedge clk); #1;
    chk("pre_rst_read", int'(ram_read), 1);
    rst = 1'b1; v = '0;
    @(negedge clk); #1;
    chk("rst6_rspv", int'(rsp_valid), 0);
    chk("rst6_busy", int'(busy), 0);
    chk("rst6_strobes", int'({ram_cs, ram_read, ram_write}), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_rspv", int'(rsp_valid), 0);
    a[1] = 4'd15;
    txn(3'b011, 0, 1'b0, 1'b1, 8'h00);
    @(negedge clk); v = '0; #1;
    chk("end_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
